// File: rtl/clks_alot_p.sv
// Shared types for the recovered-clock datapath (drift direction, scheduler states).
// Latency: n/a (types only).
// Backpressure: n/a.
package clks_alot_p;

  // Direction in which the recovered clock must be nudged.
  typedef enum logic {
    PIN_CAME_EARLY = 1'b0,
    PIN_CAME_LATE  = 1'b1
  } drift_direction_e;

  // Drift correction scheduler states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SETTLE  = 2'd2,
    RESPOND = 2'd3
  } sched_state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle type for clks_alot blocks.
// Latency: n/a (types only).
// Backpressure: n/a.
package common_p;

  // One clock domain: clock, clock enable and synchronous active-high reset.
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above ptr_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to consume the grant.
module rr_arbiter #(
  parameter  int NUM_LANES = 4,
  localparam int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_vld_o
);

  // Scan NUM_LANES candidates starting at the pointer and keep the first hit.
  always_comb begin
    int cand;
    logic found;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_LANES) cand = cand - NUM_LANES;
      if (!found && req_i[IDX_W'(cand)]) begin
        found       = 1'b1;
        grant_idx_o = IDX_W'(cand);
      end
    end
    grant_vld_o = found;
  end

endmodule

// File: rtl/drift_correction_scheduler.sv
// Shares one phase-adjust port among NUM_LANES drift accumulators; optional stats via CLKS_ALOT_DRIFT_SCHED_STATS_EN.
// Latency: adjust_req_o 1 clk_en cycle after a request seen in IDLE; drift_res_o settle_cycles_i+2 clk_en cycles after ack.
// Backpressure: adjust_req_o held until adjust_ack_i; one adjustment in flight, others wait in drift_req_i.
module drift_correction_scheduler
  import clks_alot_p::*;
#(
  parameter  int NUM_LANES    = 4,
  parameter  int SETTLE_WIDTH = 8,
  localparam int IDX_W        = $clog2(NUM_LANES)
) (
  input  common_p::clk_dom_s                      sys_dom_i,
  input  logic                                    scheduler_en_i,
  input  logic                                    clear_state_i,
  input  logic             [NUM_LANES-1:0]        drift_req_i,
  input  drift_direction_e [NUM_LANES-1:0]        drift_direction_i,
  output logic             [NUM_LANES-1:0]        drift_res_o,
  output logic                                    adjust_req_o,
  output drift_direction_e                        adjust_direction_o,
  output logic             [IDX_W-1:0]            adjust_lane_o,
  input  logic                                    adjust_ack_i,
  input  logic             [SETTLE_WIDTH-1:0]     settle_cycles_i,
  output logic                                    busy_o
`ifdef CLKS_ALOT_DRIFT_SCHED_STATS_EN
  ,
  output logic             [STATS_W-1:0]          corrections_o,
  output logic             [STATS_W-1:0]          dropped_o
`endif
);

  logic clk, clk_en, sync_rst;
  assign clk      = sys_dom_i.clk;
  assign clk_en   = sys_dom_i.clk_en;
  assign sync_rst = sys_dom_i.sync_rst;

  sched_state_e          state_q, state_d;
  logic [IDX_W-1:0]      lane_q, lane_d;
  drift_direction_e      dir_q, dir_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SETTLE_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic                  respond_fire;
  logic                  pulse;

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_rr_arbiter (
    .req_i       (drift_req_i),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (arb_idx),
    .grant_vld_o (arb_vld)
  );

  // Outputs decoded from state; the completion pulse only fires on the enabled cycle that leaves RESPOND.
  always_comb begin
    adjust_req_o       = (state_q == ISSUE);
    busy_o             = (state_q != IDLE);
    adjust_direction_o = dir_q;
    adjust_lane_o      = lane_q;
    respond_fire       = (state_q == RESPOND) && clk_en && !clear_state_i && !sync_rst;
    pulse              = respond_fire && drift_req_i[lane_q];
    drift_res_o        = '0;
    drift_res_o[lane_q] = pulse;
  end

  // Next-state logic; nothing moves on cycles where clk_en is low.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    dir_d    = dir_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (clk_en) begin
      if (clear_state_i) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (scheduler_en_i && arb_vld) begin
              lane_d  = arb_idx;
              dir_d   = drift_direction_i[arb_idx];
              state_d = ISSUE;
            end
          end
          ISSUE: begin
            if (adjust_ack_i) begin
              cnt_d   = settle_cycles_i;
              state_d = SETTLE;
            end
          end
          SETTLE: begin
            if (cnt_q == '0) state_d = RESPOND;
            else             cnt_d   = cnt_q - 1'b1;
          end
          RESPOND: begin
            rr_ptr_d = (lane_q == IDX_W'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
            state_d  = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State registers with synchronous reset that ignores clk_en.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      dir_q    <= PIN_CAME_EARLY;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      dir_q    <= dir_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CLKS_ALOT_DRIFT_SCHED_STATS_EN
  logic [STATS_W-1:0] corr_q, corr_d, drop_q, drop_d;

  // Saturating counts of completed and withdrawn corrections.
  always_comb begin
    corr_d = corr_q;
    drop_d = drop_q;
    if (clk_en && clear_state_i) begin
      corr_d = '0;
      drop_d = '0;
    end else if (respond_fire) begin
      if (pulse && (corr_q != '1))  corr_d = corr_q + 1'b1;
      if (!pulse && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end
  end

  // Stats registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      corr_q <= '0;
      drop_q <= '0;
    end else begin
      corr_q <= corr_d;
      drop_q <= drop_d;
    end
  end

  assign corrections_o = corr_q;
  assign dropped_o     = drop_q;
`endif

endmodule

// File: tb/tb_drift_correction_scheduler.sv
// Bench for drift_correction_scheduler: directed scenarios plus randomized transactions vs a transaction model.
// Latency: n/a.
// Backpressure: bench plays the generator (ack) and the accumulators (requests).
module tb_drift_correction_scheduler;
  import clks_alot_p::*;

  logic clk, clk_en, sync_rst;
  common_p::clk_dom_s sys_dom;
  assign sys_dom = {clk, clk_en, sync_rst};

  logic                   scheduler_en_i, clear_state_i, adjust_ack_i;
  logic [3:0]             req_drv;
  drift_direction_e [3:0] drift_direction_i;
  logic [3:0]             drift_res_o;
  logic                   adjust_req_o, busy_o;
  drift_direction_e       adjust_direction_o;
  logic [1:0]             adjust_lane_o;
  logic [7:0]             settle_cycles_i;
`ifdef CLKS_ALOT_DRIFT_SCHED_STATS_EN
  logic [15:0] corrections_o, dropped_o;
`endif

  drift_correction_scheduler #(.NUM_LANES(4), .SETTLE_WIDTH(8)) dut (
    .sys_dom_i          (sys_dom),
    .scheduler_en_i     (scheduler_en_i),
    .clear_state_i      (clear_state_i),
    .drift_req_i        (req_drv),
    .drift_direction_i  (drift_direction_i),
    .drift_res_o        (drift_res_o),
    .adjust_req_o       (adjust_req_o),
    .adjust_direction_o (adjust_direction_o),
    .adjust_lane_o      (adjust_lane_o),
    .adjust_ack_i       (adjust_ack_i),
    .settle_cycles_i    (settle_cycles_i),
    .busy_o             (busy_o)
`ifdef CLKS_ALOT_DRIFT_SCHED_STATS_EN
    ,
    .corrections_o      (corrections_o),
    .dropped_o          (dropped_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int en_mode  = 0;  // 0: always on, 1: random, 2: alternate, 3: forced off
  bit alt      = 1'b0;
  int m_ptr    = 0;
  int m_corr   = 0;
  int m_drop   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: choose clk_en, sample pre-edge completion pulse, advance past the edge.
  task automatic tick(output bit en, output logic [3:0] r);
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = 1'($urandom_range(0, 1));
      2:       begin alt = ~alt; clk_en = alt; end
      default: clk_en = 1'b0;
    endcase
    #1;
    r  = drift_res_o;
    en = clk_en;
    @(posedge clk);
    #1;
  endtask

  // Round-robin expectation: first requesting lane at or after ptr.
  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic wait_grant(output int edges);
    bit en; logic [3:0] r; int n;
    edges = 0; n = 0;
    while (!adjust_req_o && n < 60) begin
      tick(en, r);
      chk("res_while_idle", 32'(r), 32'd0);
      if (en) edges++;
      n++;
    end
  endtask

  task automatic check_stats();
`ifdef CLKS_ALOT_DRIFT_SCHED_STATS_EN
    chk("corrections", 32'(corrections_o), 32'(m_corr));
    chk("dropped", 32'(dropped_o), 32'(m_drop));
`endif
  endtask

  // One full grant/ack/settle/respond transaction checked against the model.
  task automatic run_txn(input int ack_delay, input int settle, input bit withdraw, input bit keep);
    int exp_lane, edges, e, guard;
    drift_direction_e exp_dir;
    logic [3:0] exp_res, r;
    bit en;
    exp_lane = pick(req_drv, m_ptr);
    exp_dir  = drift_direction_i[exp_lane];
    settle_cycles_i = 8'(settle);
    wait_grant(edges);
    chk("grant_latency", 32'(edges), 32'd1);
    chk("grant_lane", 32'(adjust_lane_o), 32'(exp_lane));
    chk("grant_dir", 32'(adjust_direction_o), 32'(exp_dir));
    chk("busy_issue", 32'(busy_o), 32'd1);
    for (int d = 0; d < ack_delay; d++) begin
      tick(en, r);
      chk("req_held", 32'(adjust_req_o), 32'd1);
      chk("lane_held", 32'(adjust_lane_o), 32'(exp_lane));
    end
    adjust_ack_i = 1'b1;
    guard = 0;
    do begin tick(en, r); guard++; end while (!en && guard < 100);
    adjust_ack_i = 1'b0;
    chk("req_drop_after_ack", 32'(adjust_req_o), 32'd0);
    if (withdraw) req_drv[exp_lane] = 1'b0;
    e = 0; guard = 0;
    while (e < settle + 2 && guard < 400) begin
      tick(en, r);
      if (en) e++;
      exp_res = '0;
      if (en && e == settle + 2 && !withdraw) exp_res[exp_lane] = 1'b1;
      chk("drift_res", 32'(r), 32'(exp_res));
      chk("req_low_settle", 32'(adjust_req_o), 32'd0);
      guard++;
    end
    chk("settle_edges", 32'(e), 32'(settle + 2));
    chk("idle_after", 32'(busy_o), 32'd0);
    m_ptr = (exp_lane + 1) % 4;
    if (withdraw) m_drop++; else m_corr++;
    if (!withdraw && !keep) req_drv[exp_lane] = 1'b0;
    check_stats();
  endtask

  initial begin
    bit en; logic [3:0] r; int edges;
    sync_rst = 1'b1; clk_en = 1'b0; scheduler_en_i = 1'b1; clear_state_i = 1'b0;
    adjust_ack_i = 1'b0; req_drv = '0; settle_cycles_i = '0;
    for (int i = 0; i < 4; i++) drift_direction_i[i] = PIN_CAME_EARLY;
    en_mode = 3;
    tick(en, r); tick(en, r);
    sync_rst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req", 32'(adjust_req_o), 32'd0);
    chk("rst_lane", 32'(adjust_lane_o), 32'd0);
    chk("rst_dir", 32'(adjust_direction_o), 32'(PIN_CAME_EARLY));
    chk("rst_res", 32'(drift_res_o), 32'd0);
    check_stats();
    en_mode = 0;

    // Fairness: lanes 0,1,3 request continuously.
    req_drv = 4'b1011;
    for (int i = 0; i < 6; i++) run_txn(0, 0, 1'b0, 1'b1);

    // Single request on lane 2, late, settle 3, ack two cycles after the request.
    req_drv = 4'b0100;
    drift_direction_i[2] = PIN_CAME_LATE;
    run_txn(2, 3, 1'b0, 1'b0);

    // Withdrawal of lane 1 during SETTLE; pointer must still advance to 2.
    req_drv = 4'b0010;
    run_txn(0, 4, 1'b1, 1'b0);
    req_drv = 4'b0101;
    run_txn(0, 1, 1'b0, 1'b1);

    // Abort in ISSUE before the ack; pointer stays, same lane re-granted.
    req_drv = 4'b1001;
    wait_grant(edges);
    chk("abort_grant_lane", 32'(adjust_lane_o), 32'(pick(req_drv, m_ptr)));
    tick(en, r);
    clear_state_i = 1'b1;
    tick(en, r);
    clear_state_i = 1'b0;
    chk("abort_res", 32'(r), 32'd0);
    chk("abort_req", 32'(adjust_req_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    m_corr = 0; m_drop = 0;
    check_stats();
    run_txn(0, 2, 1'b0, 1'b0);

    // clk_en toggling at 50% through the whole transaction.
    req_drv = 4'b0001;
    en_mode = 2;
    run_txn(1, 2, 1'b0, 1'b0);
    en_mode = 0;

    // Reset mid-SETTLE; pending request re-granted from lane 0.
    req_drv = 4'b0101;
    settle_cycles_i = 8'd5;
    wait_grant(edges);
    chk("rst_mid_lane", 32'(adjust_lane_o), 32'(pick(req_drv, m_ptr)));
    adjust_ack_i = 1'b1;
    tick(en, r);
    adjust_ack_i = 1'b0;
    tick(en, r);
    chk("rst_mid_busy_before", 32'(busy_o), 32'd1);
    sync_rst = 1'b1; en_mode = 3;
    tick(en, r);
    sync_rst = 1'b0; en_mode = 0;
    chk("rst_mid_req", 32'(adjust_req_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_lane0", 32'(adjust_lane_o), 32'd0);
    chk("rst_mid_dir", 32'(adjust_direction_o), 32'(PIN_CAME_EARLY));
    chk("rst_mid_res", 32'(drift_res_o), 32'd0);
    m_ptr = 0; m_corr = 0; m_drop = 0;
    check_stats();
    run_txn(1, 1, 1'b0, 1'b0);

    // Randomized transactions with random clk_en, ack delays, settle values and withdrawals.
    en_mode = 1;
    for (int t = 0; t < 40; t++) begin
      if (req_drv == '0) req_drv = 4'($urandom_range(1, 15));
      else req_drv = req_drv | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      for (int i = 0; i < 4; i++) drift_direction_i[i] = drift_direction_e'($urandom_range(0, 1));
      run_txn($urandom_range(0, 3), $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 1'b0);
    end
    en_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
